// File: rtl/bist_pkg.sv
// Shared definitions for the BIST pair (stimulus generator and response analyzer).
// Contents:
//   state_t  - run-control FSM encoding shared by both ends of the pair
//   POLY_16  - default 16-bit MISR/LFSR feedback polynomial (x^16 implied)
//   SEED_16  - default 16-bit signature seed
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] POLY_16 = 16'h1021;
  localparam logic [15:0] SEED_16 = 16'h0000;

endpackage

// File: rtl/response_analyzer_if.sv
// Bus between the BIST controller/datapath (master) and the response analyzer (slave).
// Signals:
//   start      controller -> analyzer  one-cycle run request
//   valid_in   datapath   -> analyzer  data_in carries a sample this cycle
//   data_in    datapath   -> analyzer  DUT output sample (WIDTH)
//   golden     controller -> analyzer  expected signature (SIG_W)
//   busy       analyzer   -> controller run in progress
//   done       analyzer   -> controller run finished, level until next start
//   pass       analyzer   -> controller signature matched golden (valid while done)
//   signature  analyzer   -> controller current MISR state (SIG_W)
//   count      analyzer   -> controller samples absorbed this run (CNT_W)
//   dbg_state  analyzer   -> observer   FSM state for checkers
//
// Handshake: there is no back-pressure. While busy=1 every cycle with
// valid_in=1 is one absorbed sample; outside a run valid_in is ignored.
// start is honoured only when busy=0 (idle or done) and is ignored during a run.
interface response_analyzer_if
  import bist_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SIG_W = 16,
  parameter int CNT_W = 12
);

  logic             start;
  logic             valid_in;
  logic [WIDTH-1:0] data_in;
  logic [SIG_W-1:0] golden;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;
  logic [CNT_W-1:0] count;
  state_t           dbg_state;

  modport master (
    output start, valid_in, data_in, golden,
    input  busy, done, pass, signature, count, dbg_state
  );

  modport slave (
    input  start, valid_in, data_in, golden,
    output busy, done, pass, signature, count, dbg_state
  );

endinterface

// File: rtl/response_analyzer_misr_step.sv
// One MISR update step, purely combinational.
// Ports:
//   sig      current signature (SIG_W)
//   din      sample to absorb (WIDTH, zero-extended into the low bits)
//   next_sig signature after shifting left, applying feedback and folding din
// The same step drives the stimulus-side LFSR (din tied to zero there).
module misr_step #(
  parameter int               WIDTH = 4,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021
) (
  input  logic [SIG_W-1:0] sig,
  input  logic [WIDTH-1:0] din,
  output logic [SIG_W-1:0] next_sig
);

  logic [SIG_W-1:0] shifted;
  logic [SIG_W-1:0] feedback;
  logic [SIG_W-1:0] din_ext;

  assign shifted  = {sig[SIG_W-2:0], 1'b0};
  // MSB leaving the register is the x^SIG_W term; reduce it by POLY.
  assign feedback = sig[SIG_W-1] ? POLY : '0;
  assign din_ext  = SIG_W'(din);
  assign next_sig = shifted ^ feedback ^ din_ext;

endmodule

// File: rtl/response_analyzer.sv
// Response analyzer: compresses SAMPLES valid DUT outputs into a MISR signature
// and compares the final signature against golden.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  response_analyzer_if.slave (start/valid_in/data_in/golden in;
//        busy/done/pass/signature/count/dbg_state out, all registered)
module response_analyzer
  import bist_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter int               SIG_W   = 16,
  parameter int               SAMPLES = 2048,
  parameter logic [SIG_W-1:0] POLY    = SIG_W'(POLY_16),
  parameter logic [SIG_W-1:0] SEED    = SIG_W'(SEED_16),
  parameter int               CNT_W   = $clog2(SAMPLES + 1)
) (
  input logic               clk,
  input logic               rst,
  response_analyzer_if.slave bus
);

  state_t           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [SIG_W-1:0] next_sig;
  logic             last_sample;

  misr_step #(
    .WIDTH (WIDTH),
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_misr_step (
    .sig      (sig_q),
    .din      (bus.data_in),
    .next_sig (next_sig)
  );

  // The sample arriving now is the final one of the run.
  assign last_sample = (cnt_q == CNT_W'(SAMPLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          sig_d   = SEED;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        // start is deliberately not looked at here: a run cannot be aborted.
        if (bus.valid_in) begin
          sig_d = next_sig;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_sample) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // Compare the signature that includes this final sample.
            pass_d  = (next_sig == bus.golden);
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.signature = sig_q;
  assign bus.count     = cnt_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_response_analyzer.sv
module tb_response_analyzer;
  import bist_pkg::*;

  localparam int          SAMPLES = 4;
  localparam logic [15:0] SEED    = 16'h0000;
  localparam int          CNT_W   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the run is the list of absorbed samples; the signature
  // is the polynomial fold of that list from SEED.
  logic [3:0]  run_q[$];
  logic [15:0] exp_q[$];
  bit          m_running = 0;
  bit          m_done    = 0;
  bit          m_pass    = 0;

  response_analyzer_if #(.WIDTH(4), .SIG_W(16), .CNT_W(CNT_W)) bus4 ();
  response_analyzer_if #(.WIDTH(4), .SIG_W(16), .CNT_W(1))     bus1 ();

  response_analyzer #(
    .WIDTH(4), .SIG_W(16), .SAMPLES(SAMPLES), .POLY(16'h1021), .SEED(SEED), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  response_analyzer #(
    .WIDTH(4), .SIG_W(16), .SAMPLES(1), .POLY(16'h1021), .SEED(16'h8000), .CNT_W(1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Multiply by x modulo x^16 + 0x1021, then add the sample.
  function automatic logic [15:0] poly_step(input logic [15:0] s, input logic [3:0] d);
    logic [16:0] t;
    t = {s, 1'b0};
    if (t[16]) t = t ^ 17'h11021;
    return t[15:0] ^ {12'h000, d};
  endfunction

  function automatic logic [15:0] fold_run();
    logic [15:0] s;
    s = SEED;
    foreach (run_q[i]) s = poly_step(s, run_q[i]);
    return s;
  endfunction

  function automatic logic [15:0] fold_arr(input logic [3:0] a0, input logic [3:0] a1,
                                           input logic [3:0] a2, input logic [3:0] a3);
    return poly_step(poly_step(poly_step(poly_step(SEED, a0), a1), a2), a3);
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_busy"}, bus4.busy, m_running);
    check({tag, "_done"}, bus4.done, m_done);
    check({tag, "_pass"}, bus4.pass, m_pass);
    check({tag, "_count"}, bus4.count, run_q.size());
    check({tag, "_sig"}, bus4.signature, fold_run());
  endtask

  // ---------------- driver ----------------
  // One clock cycle of stimulus on the SAMPLES=4 instance, with model update.
  task automatic drive(input bit s, input bit v, input logic [3:0] d, input logic [15:0] g,
                       input string tag);
    bit absorbed;
    @(negedge clk);
    bus4.start    = s;
    bus4.valid_in = v;
    bus4.data_in  = d;
    bus4.golden   = g;
    absorbed = 0;
    if (m_running) begin
      if (v) begin
        run_q.push_back(d);
        absorbed = 1;
        exp_q.push_back(fold_run());
        if (run_q.size() == SAMPLES) begin
          m_running = 0;
          m_done    = 1;
          m_pass    = (fold_run() == g);
        end
      end
    end else if (s) begin
      run_q.delete();
      m_running = 1;
      m_done    = 0;
      m_pass    = 0;
    end
    @(posedge clk);
    #1;
    bus4.start    = 1'b0;
    bus4.valid_in = 1'b0;
    if (absorbed) check({tag, "_exp"}, bus4.signature, exp_q.pop_front());
    check_outputs(tag);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) drive(0, 0, 4'h0, 16'h0, tag);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    run_q.delete();
    exp_q.delete();
    m_running = 0;
    m_done    = 0;
    m_pass    = 0;
    check_outputs(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]  d[4];
    logic [15:0] g;
    logic [15:0] good;
    bus4.start = 0; bus4.valid_in = 0; bus4.data_in = 0; bus4.golden = 0;
    bus1.start = 0; bus1.valid_in = 0; bus1.data_in = 0; bus1.golden = 0;

    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    check("reset_state", bus4.dbg_state, IDLE);
    check("reset_sig1", bus1.signature, 16'h8000);
    @(negedge clk);
    rst = 1'b0;

    // valid_in in IDLE is ignored
    drive(0, 1, 4'h7, 16'h0, "idle_valid");

    // Test 1: back-to-back 1,2,3,4 with golden 0002
    drive(1, 0, 4'h0, 16'h0002, "t1_start");
    check("t1_seed", bus4.signature, 16'h0000);
    drive(0, 1, 4'h1, 16'h0002, "t1_s1");
    check("t1_sig1", bus4.signature, 16'h0001);
    drive(0, 1, 4'h2, 16'h0002, "t1_s2");
    check("t1_sig2", bus4.signature, 16'h0000);
    drive(0, 1, 4'h3, 16'h0002, "t1_s3");
    check("t1_sig3", bus4.signature, 16'h0003);
    check("t1_notdone", bus4.done, 1'b0);
    drive(0, 1, 4'h4, 16'h0002, "t1_s4");
    check("t1_sig4", bus4.signature, 16'h0002);
    check("t1_done", bus4.done, 1'b1);
    check("t1_pass", bus4.pass, 1'b1);
    check("t1_count", bus4.count, 3'd4);
    check("t1_state", bus4.dbg_state, DONE);

    // valid_in in DONE is ignored; outputs hold
    drive(0, 1, 4'hf, 16'h0002, "done_valid");
    idle_cycles(2, "done_hold");

    // Test 6 restart from DONE, Test 2 mismatching golden
    drive(1, 0, 4'h0, 16'h0003, "t6_start");
    check("t6_busy", bus4.busy, 1'b1);
    check("t6_done", bus4.done, 1'b0);
    for (int i = 1; i <= 4; i++) drive(0, 1, 4'(i), 16'h0003, "t2_s");
    check("t2_pass", bus4.pass, 1'b0);
    check("t2_sig", bus4.signature, 16'h0002);

    // Test 4: gaps of 3 cycles and a mid-run start
    drive(1, 0, 4'h0, 16'h0002, "t4_start");
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, 4'(i), 16'h0002, "t4_s");
      if (i < 4) begin
        drive(1, 0, 4'h0, 16'h0002, "t4_midstart");
        idle_cycles(2, "t4_gap");
      end
    end
    check("t4_sig", bus4.signature, 16'h0002);
    check("t4_pass", bus4.pass, 1'b1);

    // start together with the last sample: start ignored, run completes
    drive(1, 0, 4'h0, 16'h0002, "ls_start");
    for (int i = 1; i <= 3; i++) drive(0, 1, 4'(i), 16'h0002, "ls_s");
    drive(1, 1, 4'h4, 16'h0002, "ls_last");
    check("ls_done", bus4.done, 1'b1);
    check("ls_busy", bus4.busy, 1'b0);

    // Test 5: asynchronous reset mid-run, then the Test 1 run again
    drive(1, 0, 4'h0, 16'h0002, "t5_start");
    drive(0, 1, 4'h1, 16'h0002, "t5_s1");
    drive(0, 1, 4'h2, 16'h0002, "t5_s2");
    async_reset("t5_rst");
    check("t5_rst_count", bus4.count, 3'd0);
    drive(1, 0, 4'h0, 16'h0002, "t5_restart");
    for (int i = 1; i <= 4; i++) drive(0, 1, 4'(i), 16'h0002, "t5_s");
    check("t5_sig", bus4.signature, 16'h0002);
    check("t5_pass", bus4.pass, 1'b1);

    // Test 3: SAMPLES=1, SEED=8000, feedback path
    @(negedge clk);
    bus1.start = 1'b1;
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    check("t3_busy", bus1.busy, 1'b1);
    check("t3_seed", bus1.signature, 16'h8000);
    @(negedge clk);
    bus1.valid_in = 1'b1;
    bus1.data_in  = 4'h0;
    bus1.golden   = 16'h1021;
    @(posedge clk);
    #1;
    bus1.valid_in = 1'b0;
    check("t3_sig", bus1.signature, 16'h1021);
    check("t3_done", bus1.done, 1'b1);
    check("t3_pass", bus1.pass, 1'b1);
    check("t3_busy_end", bus1.busy, 1'b0);
    check("t3_count", bus1.count, 1'b1);

    // Randomized runs: random data, gaps, stray starts/valids, pass or fail golden
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 4; i++) d[i] = 4'($urandom_range(0, 15));
      good = fold_arr(d[0], d[1], d[2], d[3]);
      g = ($urandom_range(0, 1) == 1) ? good : (good ^ 16'($urandom_range(1, 16'hffff)));
      if ($urandom_range(0, 3) == 0) drive(0, 1, 4'($urandom_range(0, 15)), g, "rnd_pre");
      drive(1, 0, 4'h0, g, "rnd_start");
      for (int i = 0; i < 4; i++) begin
        for (int k = $urandom_range(0, 3); k > 0; k--)
          drive(bit'($urandom_range(0, 1)), 0, 4'($urandom_range(0, 15)), g, "rnd_gap");
        drive(bit'($urandom_range(0, 1)), 1, d[i], g, "rnd_s");
      end
      check("rnd_final_sig", bus4.signature, good);
      check("rnd_final_pass", bus4.pass, (good == g));
      if ($urandom_range(0, 7) == 0) async_reset("rnd_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #500000;
    n_fail++;
    $display("FAIL timeout: simulation exceeded time bound");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
